// File: rtl/v_datamem_responder.sv
// rtl/v_datamem_responder.sv - 4-lane data-memory responder over 4 word-interleaved SRAM banks
//
// Purpose: accepts one vector memory beat (4 lane addresses, store data or a
// load), serves it from 4 single-port banks selected by addr[1:0], serialises
// lanes that collide on a bank, and returns the 4 load words (or a store ack)
// through a valid/ready response.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   req_valid_i    request present
//   req_ready_o    responder can accept (IDLE only)
//   req_we_i       1 = store beat, 0 = load beat
//   req_lane_en_i  per-lane enable; disabled lanes are not accessed
//   req_addr_i     lane i word address in [i*ADDR_W +: ADDR_W]
//   req_wdata_i    lane i store data in [i*DATA_W +: DATA_W]
//   rsp_valid_o    response present
//   rsp_ready_i    consumer takes response
//   rsp_rdata_o    lane i load data; 0 for stores and disabled lanes
//   busy_o         responder not in IDLE
module v_datamem_responder #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [3:0]            req_lane_en_i,
  input  logic [4*ADDR_W-1:0]   req_addr_i,
  input  logic [4*DATA_W-1:0]   req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [4*DATA_W-1:0]   rsp_rdata_o,
  output logic                  busy_o
);

  localparam int ROW_W = ADDR_W - 2;
  localparam int DEPTH = 1 << ROW_W;

  typedef enum logic [1:0] {IDLE, SERVE, WAIT, RESP} state_e;

  state_e              state_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q   [4];
  logic [DATA_W-1:0]   wdata_q  [4];
  logic [DATA_W-1:0]   rdata_q  [4];
  logic [3:0]          pending_q;
  logic [3:0]          rd_grant_q;   // lanes whose bank read was issued last cycle

  logic [3:0]          grant_d;
  logic [3:0]          pending_d;
  logic [3:0]          bank_hit;
  logic [1:0]          bank_lane [4];
  logic [4*DATA_W-1:0] bank_rd_flat;
  logic [DATA_W-1:0]   bank_rd   [4];

  // Per-bank arbitration: scanning lanes from high to low leaves the
  // lowest-numbered pending lane as the winner, so same-address stores
  // finish with the highest enabled lane.
  always_comb begin
    grant_d  = '0;
    bank_hit = '0;
    for (int b = 0; b < 4; b++) begin
      bank_lane[b] = '0;
    end
    if (state_q == SERVE) begin
      for (int b = 0; b < 4; b++) begin
        for (int l = 3; l >= 0; l--) begin
          if (pending_q[l] && (addr_q[l][1:0] == 2'(b))) begin
            bank_hit[b]  = 1'b1;
            bank_lane[b] = 2'(l);
          end
        end
      end
      for (int b = 0; b < 4; b++) begin
        if (bank_hit[b]) begin
          grant_d[bank_lane[b]] = 1'b1;
        end
      end
    end
    pending_d = pending_q & ~grant_d;
  end

  for (genvar gb = 0; gb < 4; gb++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_q;
    logic [ROW_W-1:0]  row;
    logic [DATA_W-1:0] wd;

    assign row = addr_q[bank_lane[gb]][ADDR_W-1:2];
    assign wd  = wdata_q[bank_lane[gb]];

    // Writes are suppressed while rst_i is high so a reset mid-beat never
    // commits a grant it interrupts.
    always_ff @(posedge clk_i) begin
      if (!rst_i && bank_hit[gb]) begin
        if (we_q) begin
          mem[row] <= wd;
        end else begin
          rd_q <= mem[row];
        end
      end
    end

    assign bank_rd_flat[gb*DATA_W +: DATA_W] = rd_q;
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bank_rd[b] = bank_rd_flat[b*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      pending_q  <= '0;
      rd_grant_q <= '0;
      for (int l = 0; l < 4; l++) begin
        addr_q[l]  <= '0;
        wdata_q[l] <= '0;
        rdata_q[l] <= '0;
      end
    end else begin
      rd_grant_q <= (state_q == SERVE && !we_q) ? grant_d : 4'b0;
      // Read data lands one cycle after its grant; route by the lane's bank.
      for (int l = 0; l < 4; l++) begin
        if (rd_grant_q[l]) begin
          rdata_q[l] <= bank_rd[addr_q[l][1:0]];
        end
      end
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            we_q      <= req_we_i;
            pending_q <= req_lane_en_i;
            for (int l = 0; l < 4; l++) begin
              addr_q[l]  <= req_addr_i[l*ADDR_W +: ADDR_W];
              wdata_q[l] <= req_wdata_i[l*DATA_W +: DATA_W];
              rdata_q[l] <= '0;
            end
            state_q <= (req_lane_en_i == 4'b0) ? RESP : SERVE;
          end
        end
        SERVE: begin
          pending_q <= pending_d;
          if (pending_d == 4'b0) begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign busy_o      = (state_q != IDLE);

  always_comb begin
    rsp_rdata_o = '0;
    for (int l = 0; l < 4; l++) begin
      rsp_rdata_o[l*DATA_W +: DATA_W] = rdata_q[l];
    end
  end

endmodule
